// File: rtl/pa_pmp_lsu_chk.sv
// LSU-side PMP check sequencer: drives the shared comparator one beat at a time,
// splits granule-crossing accesses into two beats and returns one merged response.
module pa_pmp_lsu_chk #(
   parameter int ADDR_WIDTH = 32,
   parameter int GRAN_BITS  = 2
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  lsu_pmp_req_vld,
   output logic                  pmp_lsu_req_rdy,
   input  logic [ADDR_WIDTH-1:0] lsu_pmp_req_addr,
   input  logic [1:0]            lsu_pmp_req_size,
   input  logic                  lsu_pmp_req_write,
   input  logic                  lsu_pmp_flush,
   output logic                  pmp_comp_vld,
   output logic [ADDR_WIDTH-1:0] pmp_comp_addr,
   output logic                  pmp_comp_write,
   input  logic                  pmp_lsu_acc_deny,
   output logic                  pmp_lsu_rsp_vld,
   input  logic                  lsu_pmp_rsp_rdy,
   output logic                  pmp_lsu_rsp_deny,
   output logic [ADDR_WIDTH-1:0] pmp_lsu_rsp_fault_addr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CHK0 = 2'd1,
      CHK1 = 2'd2,
      RSP  = 2'd3
   } state_t;

   // Offset width must hold (2**GRAN_BITS - 1) + 4 - 1 without overflow.
   localparam int OW = GRAN_BITS + 3;
   localparam int HW = ADDR_WIDTH - GRAN_BITS;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  cross_q;

   logic [1:0]            size_eff;
   logic [OW-1:0]         end_off;
   logic                  req_cross;
   logic                  req_acc;
   logic [HW-1:0]         gran_inc;
   logic [ADDR_WIDTH-1:0] next_gran_addr;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      size_eff       = (lsu_pmp_req_size == 2'd3) ? 2'd2 : lsu_pmp_req_size;
      end_off        = OW'(lsu_pmp_req_addr[GRAN_BITS-1:0]) + (OW'(1) << size_eff) - OW'(1);
      req_cross      = (end_off >= (OW'(1) << GRAN_BITS));
      req_acc        = lsu_pmp_req_vld & pmp_lsu_req_rdy & ~lsu_pmp_flush;
      gran_inc       = addr_q[ADDR_WIDTH-1:GRAN_BITS] + HW'(1);
      next_gran_addr = {gran_inc, {GRAN_BITS{1'b0}}};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         // NOTE: every register here is a plain flop, so all of them take a reset
         // value; a reset mid-access simply drops it.
         state                  <= IDLE;
         addr_q                 <= '0;
         cross_q                <= 1'b0;
         pmp_lsu_req_rdy        <= 1'b1;
         pmp_comp_vld           <= 1'b0;
         pmp_comp_addr          <= '0;
         pmp_comp_write         <= 1'b0;
         pmp_lsu_rsp_vld        <= 1'b0;
         pmp_lsu_rsp_deny       <= 1'b0;
         pmp_lsu_rsp_fault_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_acc) begin
                  addr_q                 <= lsu_pmp_req_addr;
                  cross_q                <= req_cross;
                  pmp_comp_write         <= lsu_pmp_req_write;
                  pmp_comp_addr          <= lsu_pmp_req_addr;
                  pmp_comp_vld           <= 1'b1;
                  pmp_lsu_req_rdy        <= 1'b0;
                  pmp_lsu_rsp_deny       <= 1'b0;
                  pmp_lsu_rsp_fault_addr <= '0;
                  state                  <= CHK0;
               end
            end

            CHK0: begin
               if (lsu_pmp_flush) begin
                  state           <= IDLE;
                  pmp_comp_vld    <= 1'b0;
                  pmp_lsu_req_rdy <= 1'b1;
               end else if (pmp_lsu_acc_deny) begin
                  // First-beat fault: the second beat is never presented.
                  state                  <= RSP;
                  pmp_comp_vld           <= 1'b0;
                  pmp_lsu_rsp_vld        <= 1'b1;
                  pmp_lsu_rsp_deny       <= 1'b1;
                  pmp_lsu_rsp_fault_addr <= addr_q;
               end else if (cross_q) begin
                  state         <= CHK1;
                  pmp_comp_addr <= next_gran_addr;
               end else begin
                  state           <= RSP;
                  pmp_comp_vld    <= 1'b0;
                  pmp_lsu_rsp_vld <= 1'b1;
               end
            end

            CHK1: begin
               if (lsu_pmp_flush) begin
                  state           <= IDLE;
                  pmp_comp_vld    <= 1'b0;
                  pmp_lsu_req_rdy <= 1'b1;
               end else begin
                  state                  <= RSP;
                  pmp_comp_vld           <= 1'b0;
                  pmp_lsu_rsp_vld        <= 1'b1;
                  pmp_lsu_rsp_deny       <= pmp_lsu_acc_deny;
                  pmp_lsu_rsp_fault_addr <= pmp_lsu_acc_deny ? pmp_comp_addr : '0;
               end
            end

            RSP: begin
               if (lsu_pmp_flush || lsu_pmp_rsp_rdy) begin
                  state            <= IDLE;
                  pmp_lsu_rsp_vld  <= 1'b0;
                  pmp_lsu_req_rdy  <= 1'b1;
               end
            end

            default: begin
               state           <= IDLE;
               pmp_comp_vld    <= 1'b0;
               pmp_lsu_rsp_vld <= 1'b0;
               pmp_lsu_req_rdy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pa_pmp_lsu_chk.sv
// Scoreboard bench for pa_pmp_lsu_chk: a per-access reference model predicts the
// comparator beats and the merged response; negedge monitors pop and compare.
module tb_pa_pmp_lsu_chk;

   localparam int AW = 32;
   localparam int G  = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_vld = 1'b0;
   logic          req_rdy;
   logic [AW-1:0] req_addr = '0;
   logic [1:0]    req_size = '0;
   logic          req_write = 1'b0;
   logic          flush = 1'b0;
   logic          comp_vld;
   logic [AW-1:0] comp_addr;
   logic          comp_write;
   logic          acc_deny;
   logic          rsp_vld;
   logic          rsp_rdy = 1'b0;
   logic          rsp_deny;
   logic [AW-1:0] rsp_fault;

   always #5 clk = ~clk;

   pa_pmp_lsu_chk #(.ADDR_WIDTH(AW), .GRAN_BITS(G)) dut (
      .forever_cpuclk         (clk),
      .cpurst_b               (rst_n),
      .lsu_pmp_req_vld        (req_vld),
      .pmp_lsu_req_rdy        (req_rdy),
      .lsu_pmp_req_addr       (req_addr),
      .lsu_pmp_req_size       (req_size),
      .lsu_pmp_req_write      (req_write),
      .lsu_pmp_flush          (flush),
      .pmp_comp_vld           (comp_vld),
      .pmp_comp_addr          (comp_addr),
      .pmp_comp_write         (comp_write),
      .pmp_lsu_acc_deny       (acc_deny),
      .pmp_lsu_rsp_vld        (rsp_vld),
      .lsu_pmp_rsp_rdy        (rsp_rdy),
      .pmp_lsu_rsp_deny       (rsp_deny),
      .pmp_lsu_rsp_fault_addr (rsp_fault)
   );

   typedef struct {
      logic          deny;
      logic [AW-1:0] fault;
      int            lat;
      int            acc;
   } rsp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          wr;
   } beat_t;

   rsp_t  rsp_q[$];
   beat_t beat_q[$];
   rsp_t  r_head;
   beat_t b_head;
   bit    seen = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

   // Per-access deny pattern served to the DUT as the PMP encoder would.
   logic [AW-1:0] cur_b0 = '0;
   logic [AW-1:0] cur_b1 = '0;
   logic          cur_cross = 1'b0;
   logic          cur_d0 = 1'b0;
   logic          cur_d1 = 1'b0;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Unknown comparator addresses are denied so a misdirected beat shows up as a fault.
   always_comb begin
      acc_deny = 1'b0;
      if (comp_vld) begin
         if (comp_addr == cur_b0)                    acc_deny = cur_d0;
         else if (cur_cross && comp_addr == cur_b1)  acc_deny = cur_d1;
         else                                        acc_deny = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       rsp_rdy = ($urandom_range(3) != 0);
         1:       rsp_rdy = 1'b0;
         default: rsp_rdy = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (comp_vld) begin
         if (beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got addr %h expected no beat (cycle %0d)", comp_addr, cyc);
         end else begin
            b_head = beat_q.pop_front();
            check("beat_addr", comp_addr, b_head.addr);
            check("beat_write", comp_write, b_head.wr);
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_vld) begin
         if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got deny=%b fault=%h expected no response", rsp_deny, rsp_fault);
         end else begin
            r_head = rsp_q[0];
            if (!seen) begin
               seen = 1'b1;
               // rsp_vld visible after edge cyc is sampled by the LSU at edge cyc+1.
               check("rsp_latency", cyc + 1 - r_head.acc, r_head.lat);
            end
            check("rsp_deny", rsp_deny, r_head.deny);
            check("rsp_fault_addr", rsp_fault, r_head.fault);
            check("req_rdy_in_rsp", req_rdy, 1'b0);
            if (rsp_rdy) begin
               void'(rsp_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Call at #1 after a posedge; returns at #1 after the accept edge.
   task automatic send(input logic [AW-1:0] a, input logic [1:0] sz, input logic wr,
                       input logic d0, input logic d1, input bit exp_rsp);
      int            n;
      int            nbytes;
      logic [AW-1:0] last;
      logic [AW-1:0] b1;
      bit            cr;
      rsp_t          r;
      beat_t         b;
      nbytes = 1 << ((sz == 2'd3) ? 2 : int'(sz));
      last   = a + nbytes - 1;
      cr     = ((last >> G) != (a >> G));
      b1     = ((a >> G) + 1) << G;
      n = 0;
      while (!req_rdy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_rdy) begin
         total++;
         bad++;
         $display("FAIL req_rdy_timeout: got req_rdy=0 expected 1 within 200 cycles");
         return;
      end
      cur_b0 = a; cur_b1 = b1; cur_cross = cr; cur_d0 = d0; cur_d1 = d1;
      req_addr = a; req_size = sz; req_write = wr; req_vld = 1'b1;
      @(posedge clk);
      #1;
      req_vld = 1'b0;
      b.addr = a; b.wr = wr;
      beat_q.push_back(b);
      if (cr && !d0) begin
         b.addr = b1;
         beat_q.push_back(b);
      end
      if (exp_rsp) begin
         r.deny  = d0 | (cr & d1);
         r.fault = d0 ? a : ((cr && d1) ? b1 : '0);
         r.lat   = (cr && !d0) ? 3 : 2;
         r.acc   = cyc;
         rsp_q.push_back(r);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || beat_q.size() != 0 || !req_rdy) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d rsp pending expected 0", rsp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_req_rdy", req_rdy, 1'b1);
      check("rst_rsp_vld", rsp_vld, 1'b0);
      check("rst_comp_vld", comp_vld, 1'b0);
      check("rst_comp_addr", comp_addr, '0);
      check("rst_comp_write", comp_write, 1'b0);
      check("rst_rsp_deny", rsp_deny, 1'b0);
      check("rst_fault_addr", rsp_fault, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases.
      rdy_mode = 2;
      send(32'h8000_0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1); wait_drain();
      send(32'h8000_0FFF, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1); wait_drain();
      send(32'h2000_0002, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1); wait_drain();
      send(32'hFFFF_FFFF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1); wait_drain();
      send(32'hFFFF_FFFF, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1); wait_drain();
      send(32'h1000_0001, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1); wait_drain();
      send(32'h1000_0003, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1); wait_drain();
      send(32'h1000_0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1); wait_drain();

      // Response back-pressure: fields stay stable, no new accept.
      rdy_mode = 1;
      send(32'h4000_0006, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("stall_rsp_vld", rsp_vld, 1'b1);
      rdy_mode = 2;
      wait_drain();

      // Flush in IDLE blocks acceptance.
      req_addr = 32'h6000_0000; req_size = 2'd2; req_vld = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      req_vld = 1'b0; flush = 1'b0;
      check("idle_flush_comp_vld", comp_vld, 1'b0);
      check("idle_flush_req_rdy", req_rdy, 1'b1);

      // Flush in CHK1.
      send(32'h3000_0006, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_rsp_vld", rsp_vld, 1'b0);
      check("flush_req_rdy", req_rdy, 1'b1);
      check("flush_comp_vld", comp_vld, 1'b0);
      send(32'h3000_0010, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1); wait_drain();

      // Asynchronous reset in CHK0.
      send(32'h5000_0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      #5 rst_n = 1'b0;
      #1;
      check("arst_rsp_vld", rsp_vld, 1'b0);
      check("arst_req_rdy", req_rdy, 1'b1);
      check("arst_comp_vld", comp_vld, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(32'h5000_0002, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1); wait_drain();

      // Randomized traffic with random response back-pressure.
      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         logic [AW-1:0] a;
         a = $urandom;
         if ($urandom_range(1) == 0) a[3:0] = 4'hF;
         send(a, 2'($urandom_range(3)), 1'($urandom_range(1)),
              ($urandom_range(3) == 0), ($urandom_range(2) == 0), 1'b1);
      end
      rdy_mode = 2;
      wait_drain();

      check("rsp_q_empty", rsp_q.size(), 0);
      check("beat_q_empty", beat_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
